// File: rtl/calc_sequencer_pkg.sv
// Shared types and constants for the calculator instruction sequencer.
package calc_sequencer_pkg;

    localparam int unsigned INSTR_W    = 23;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REG_IDX_W  = 3;
    localparam int unsigned CTRL_W     = 4;
    localparam int unsigned OP_CNT_W   = 16;
    localparam int unsigned DUMP_COUNT = 8;

    // Bit positions of the instruction word fields
    localparam int unsigned DUMP_BIT = 22;
    localparam int unsigned CTRL_LSB = 18;
    localparam int unsigned RW_LSB   = 15;
    localparam int unsigned RX_LSB   = 12;
    localparam int unsigned RY_LSB   = 9;
    localparam int unsigned SEL_BIT  = 8;
    localparam int unsigned IMM_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DUMP  = 2'd2
    } state_e;

    typedef struct packed {
        logic                 dump;
        logic [CTRL_W-1:0]    ctrl;
        logic [REG_IDX_W-1:0] rw;
        logic [REG_IDX_W-1:0] rx;
        logic [REG_IDX_W-1:0] ry;
        logic                 sel;
        logic [DATA_W-1:0]    imm;
    } instr_t;

    // Split a raw instruction word into its fields
    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
        instr_t f;
        f.dump = w[DUMP_BIT];
        f.ctrl = w[CTRL_LSB +: CTRL_W];
        f.rw   = w[RW_LSB +: REG_IDX_W];
        f.rx   = w[RX_LSB +: REG_IDX_W];
        f.ry   = w[RY_LSB +: REG_IDX_W];
        f.sel  = w[SEL_BIT];
        f.imm  = w[IMM_LSB +: DATA_W];
        return f;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Instruction, calculator-control and dump-stream signals of the sequencer.
// Optional carry_flag exists only when CALC_SEQ_CARRY_FLAG_EN is defined.
interface calc_sequencer_if;
    import calc_sequencer_pkg::*;

    logic                 instr_valid;
    logic [INSTR_W-1:0]   instr;
    logic                 instr_ready;
    logic                 WEN;
    logic [REG_IDX_W-1:0] RW;
    logic [REG_IDX_W-1:0] RX;
    logic [REG_IDX_W-1:0] RY;
    logic                 Sel;
    logic [CTRL_W-1:0]    Ctrl;
    logic [DATA_W-1:0]    DataIn;
    logic [DATA_W-1:0]    busY;
    logic                 Carry;
    logic                 dump_valid;
    logic [DATA_W-1:0]    dump_data;
    logic [REG_IDX_W-1:0] dump_idx;
    logic                 dump_ready;
`ifdef CALC_SEQ_CARRY_FLAG_EN
    logic                 carry_flag;
`endif

    // Environment side: upstream instructions, calculator, dump sink
    modport master (
        output instr_valid, instr, busY, Carry, dump_ready,
        input  instr_ready, WEN, RW, RX, RY, Sel, Ctrl, DataIn,
               dump_valid, dump_data, dump_idx
`ifdef CALC_SEQ_CARRY_FLAG_EN
        , input carry_flag
`endif
    );

    // Sequencer side
    modport slave (
        input  instr_valid, instr, busY, Carry, dump_ready,
        output instr_ready, WEN, RW, RX, RY, Sel, Ctrl, DataIn,
               dump_valid, dump_data, dump_idx
`ifdef CALC_SEQ_CARRY_FLAG_EN
        , output carry_flag
`endif
    );

endinterface

// File: rtl/calc_sequencer.sv
// Calculator instruction sequencer: issues one ALU instruction per two cycles
// and streams the 8-entry register file out on request.
// Optional feature macro: CALC_SEQ_CARRY_FLAG_EN adds a registered carry_flag.
module calc_sequencer
    import calc_sequencer_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    calc_sequencer_if.slave bus
);

    state_e               state_q, state_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;
    logic [OP_CNT_W-1:0]  op_count_q, op_count_d;
    logic                 instr_ready_q, instr_ready_d;
    logic                 wen_q, wen_d;
    logic [REG_IDX_W-1:0] rw_q, rw_d;
    logic [REG_IDX_W-1:0] rx_q, rx_d;
    logic [REG_IDX_W-1:0] ry_q, ry_d;
    logic                 sel_q, sel_d;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic [DATA_W-1:0]    data_in_q, data_in_d;
    logic                 dump_valid_q, dump_valid_d;
`ifdef CALC_SEQ_CARRY_FLAG_EN
    logic                 carry_flag_q, carry_flag_d;
`endif

    instr_t fields;
    logic   accept;
    logic   dump_hs;

    assign fields  = decode_instr(bus.instr);
    assign accept  = bus.instr_valid && instr_ready_q;
    assign dump_hs = dump_valid_q && bus.dump_ready;

    // Next-state and next-output logic for the IDLE/ISSUE/DUMP sequencer
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        op_count_d   = op_count_q;
        wen_d        = 1'b0;
        rw_d         = rw_q;
        rx_d         = rx_q;
        ry_d         = ry_q;
        sel_d        = sel_q;
        ctrl_d       = ctrl_q;
        data_in_d    = data_in_q;
        dump_valid_d = dump_valid_q;
`ifdef CALC_SEQ_CARRY_FLAG_EN
        carry_flag_d = carry_flag_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (fields.dump) begin
                        state_d      = ST_DUMP;
                        idx_d        = '0;
                        ry_d         = '0;
                        dump_valid_d = 1'b1;
                    end else begin
                        state_d   = ST_ISSUE;
                        wen_d     = 1'b1;
                        rw_d      = fields.rw;
                        rx_d      = fields.rx;
                        ry_d      = fields.ry;
                        sel_d     = fields.sel;
                        ctrl_d    = fields.ctrl;
                        data_in_d = fields.imm;
                    end
                end
            end
            ST_ISSUE: begin
                state_d    = ST_IDLE;
                op_count_d = op_count_q + OP_CNT_W'(1);
`ifdef CALC_SEQ_CARRY_FLAG_EN
                carry_flag_d = bus.Carry;
`endif
            end
            ST_DUMP: begin
                if (dump_hs) begin
                    if (idx_q == REG_IDX_W'(DUMP_COUNT - 1)) begin
                        state_d      = ST_IDLE;
                        idx_d        = '0;
                        dump_valid_d = 1'b0;
                    end else begin
                        idx_d = idx_q + REG_IDX_W'(1);
                        ry_d  = idx_d;
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                dump_valid_d = 1'b0;
            end
        endcase

        instr_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset wins over any handshake
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            op_count_q    <= '0;
            instr_ready_q <= 1'b1;
            wen_q         <= 1'b0;
            rw_q          <= '0;
            rx_q          <= '0;
            ry_q          <= '0;
            sel_q         <= 1'b0;
            ctrl_q        <= '0;
            data_in_q     <= '0;
            dump_valid_q  <= 1'b0;
`ifdef CALC_SEQ_CARRY_FLAG_EN
            carry_flag_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            op_count_q    <= op_count_d;
            instr_ready_q <= instr_ready_d;
            wen_q         <= wen_d;
            rw_q          <= rw_d;
            rx_q          <= rx_d;
            ry_q          <= ry_d;
            sel_q         <= sel_d;
            ctrl_q        <= ctrl_d;
            data_in_q     <= data_in_d;
            dump_valid_q  <= dump_valid_d;
`ifdef CALC_SEQ_CARRY_FLAG_EN
            carry_flag_q  <= carry_flag_d;
`endif
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.WEN         = wen_q;
    assign bus.RW          = rw_q;
    assign bus.RX          = rx_q;
    assign bus.RY          = ry_q;
    assign bus.Sel         = sel_q;
    assign bus.Ctrl        = ctrl_q;
    assign bus.DataIn      = data_in_q;
    assign bus.dump_valid  = dump_valid_q;
    assign bus.dump_idx    = idx_q;
    // Register-file read data passes straight through while a dump word is offered
    assign bus.dump_data   = dump_valid_q ? bus.busY : '0;
`ifdef CALC_SEQ_CARRY_FLAG_EN
    assign bus.carry_flag  = carry_flag_q;
`endif

endmodule
